uart_rx_frame: RTL and testbench

UART receive framer for the 26 MHz UART. It synchronises the serial input `rxd` and detects the start-bit falling edge. It drives `rx_bps_en` to the baud generator and samples each bit on the generator's mid-bit `rx_bpsclk` pulse. It assembles 8N1/8E1/8O1 frames into a one-entry holding register that the register/bus side reads with a level-valid/read-strobe handshake.

---
 rtl/uart_rx_frame.sv | 97 +++++++++
 tb/tb_uart_rx_frame.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1/8E1/8O1 UART receive framer with a one-entry holding register.
module uart_rx_frame #(
   parameter int DATA_W = 8
) (
   input  logic              clk26m,
   input  logic              rst26m,
   input  logic              rxd,
   input  logic              rx_bpsclk,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              rx_rd,
   output logic              rx_bps_en,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_frame_err,
   output logic              rx_parity_err,
   output logic              rx_overrun
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state;
   logic s1, s2, s3;
   logic [2:0] idx;
   logic [DATA_W-1:0] shreg;
   logic par_en, par_odd, par_bit;
   logic fall, done, load;
   assign fall = s3 & ~s2;
   assign done = (state == STOP) & rx_bpsclk;
   assign load = ~rx_valid | rx_rd;
   always_ff @(posedge clk26m) begin
      if (rst26m) begin
         s1            <= 1'b1;
         s2            <= 1'b1;
         s3            <= 1'b1;
         state         <= IDLE;
         idx           <= '0;
         shreg         <= '0;
         par_en        <= 1'b0;
         par_odd       <= 1'b0;
         par_bit       <= 1'b0;
         rx_bps_en     <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         s1 <= rxd;
         s2 <= s1;
         s3 <= s2;
         case (state)
            IDLE: if (fall) begin
               state     <= START;
               rx_bps_en <= 1'b1;
               par_en    <= parity_en;
               par_odd   <= parity_odd;
            end
            START: if (rx_bpsclk) begin
               // a start bit that is high again at mid-bit was only a glitch
               state     <= s2 ? IDLE : DATA;
               rx_bps_en <= ~s2;
               idx       <= '0;
            end
            DATA: if (rx_bpsclk) begin
               shreg[idx] <= s2;
               idx        <= idx + 3'd1;
               if (idx == 3'd7) state <= par_en ? PARITY : STOP;
            end
            PARITY: if (rx_bpsclk) begin
               par_bit <= s2;
               state   <= STOP;
            end
            STOP: if (rx_bpsclk) begin
               state     <= IDLE;
               rx_bps_en <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         // a completing frame wins over a plain read; a read in the same cycle frees the slot
         if (done) begin
            if (load) begin
               rx_data       <= shreg;
               rx_valid      <= 1'b1;
               rx_frame_err  <= ~s2;
               rx_parity_err <= par_en & (^shreg ^ par_bit ^ par_odd);
               rx_overrun    <= 1'b0;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_rd & rx_valid) begin
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and randomized frames checked against a holding-register model.
module tb_uart_rx_frame;
   localparam int P = 17;
   localparam int MID = 8;
   logic clk26m = 1'b0;
   logic rst26m, rxd, rx_bpsclk, parity_en, parity_odd, rx_rd;
   logic rx_bps_en, rx_valid, rx_frame_err, rx_parity_err, rx_overrun;
   logic [7:0] rx_data;
   logic [4:0] bcnt = '0;
   int n_pass = 0, n_total = 0;
   int cyc = 0, t_fall = 0, t_enrise = 0, t_enfall = 0, n_enfall = 0;
   logic en_q = 1'b0;
   logic m_valid, m_ferr, m_perr, m_ovr;
   logic [7:0] m_data;

   uart_rx_frame #(.DATA_W(8)) dut (
      .clk26m(clk26m), .rst26m(rst26m), .rxd(rxd), .rx_bpsclk(rx_bpsclk),
      .parity_en(parity_en), .parity_odd(parity_odd), .rx_rd(rx_rd),
      .rx_bps_en(rx_bps_en), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
   );

   always #5 clk26m = ~clk26m;
   always @(posedge clk26m) cyc++;
   // baud generator: period P, pulse at count MID, held in reset while disabled
   always @(posedge clk26m) bcnt <= !rx_bps_en ? 5'd0 : (bcnt == 5'(P - 1) ? 5'd0 : bcnt + 5'd1);
   assign rx_bpsclk = rx_bps_en && bcnt == 5'(MID);
   always @(negedge clk26m) begin
      if (!en_q && rx_bps_en === 1'b1) t_enrise = cyc;
      if (en_q && rx_bps_en === 1'b0) begin
         t_enfall = cyc;
         n_enfall++;
      end
      en_q = (rx_bps_en === 1'b1);
   end
   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check1(input string tag, input logic got, input logic exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%b exp=%b", tag, got, exp);
   endtask
   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask
   task automatic checki(input string tag, input int got, input int exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask
   task automatic check_all(input string tag);
      check8({tag, ".data"}, rx_data, m_data);
      check1({tag, ".valid"}, rx_valid, m_valid);
      check1({tag, ".ferr"}, rx_frame_err, m_ferr);
      check1({tag, ".perr"}, rx_parity_err, m_perr);
      check1({tag, ".ovr"}, rx_overrun, m_ovr);
   endtask

   task automatic model_complete(input logic [7:0] d, input logic pen, podd, pbit, stop, rd);
      if (!m_valid || rd) begin
         m_data  = d;
         m_valid = 1'b1;
         m_ferr  = !stop;
         m_perr  = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
         m_ovr   = 1'b0;
      end else m_ovr = 1'b1;
   endtask
   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (P) @(negedge clk26m);
   endtask
   task automatic read();
      rx_rd = 1'b1;
      @(negedge clk26m);
      rx_rd = 1'b0;
      if (m_valid) {m_valid, m_ferr, m_perr, m_ovr} = 4'b0;
   endtask
   task automatic frame(input string tag, input logic [7:0] d, input logic pen, podd, pbit, stop, rd);
      int nbits = pen ? 11 : 10;
      int pulses = 0;
      parity_en = pen;
      parity_odd = podd;
      fork
         begin
            t_fall = cyc;
            drive_bit(1'b0);
            for (int i = 0; i < 8; i++) drive_bit(d[i]);
            if (pen) drive_bit(pbit);
            drive_bit(stop);
            rxd = 1'b1;
         end
         begin
            for (int lim = 0; lim < 400 && pulses < nbits; lim++) begin
               @(negedge clk26m);
               if (rx_bpsclk === 1'b1) begin
                  pulses++;
                  if (pulses == nbits && rd) rx_rd = 1'b1;
               end
            end
            if (rd) begin
               @(negedge clk26m);
               rx_rd = 1'b0;
            end
         end
      join
      checki({tag, ".pulses"}, pulses, nbits);
      repeat (2) @(negedge clk26m);
      model_complete(d, pen, podd, pbit, stop, rd);
      check_all(tag);
      check1({tag, ".en_off"}, rx_bps_en, 1'b0);
   endtask

   initial begin
      int n0;
      logic [7:0] d;
      logic pen, podd, pbit, stop, rd;
      rst26m = 1'b1; rxd = 1'b1; rx_rd = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
      {m_valid, m_ferr, m_perr, m_ovr} = 4'b0;
      m_data = 8'h00;
      repeat (3) @(negedge clk26m);
      rst26m = 1'b0;
      @(negedge clk26m);
      check_all("reset");
      check1("reset.en", rx_bps_en, 1'b0);
      // 8N1 with enable-window timing measured from the start-bit fall
      frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checki("a5.en_window", t_enfall - t_fall, 3 + 9 * P + MID + 1);
      read();
      check1("a5.read_valid", rx_valid, 1'b0);
      check8("a5.read_data", rx_data, 8'hA5);
      frame("even_ok", 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      read();
      frame("even_bad", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      read();
      frame("odd_ok", 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      read();
      // break: line held low for 20 bit periods yields exactly one frame
      parity_en = 1'b0;
      n0 = n_enfall;
      rxd = 1'b0;
      repeat (20 * P) @(negedge clk26m);
      model_complete(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("break");
      checki("break.frames", n_enfall - n0, 1);
      rxd = 1'b1;
      repeat (12 * P) @(negedge clk26m);
      checki("break.no_second", n_enfall - n0, 1);
      read();
      // glitch: 4 cycles low must not produce a frame
      n0 = n_enfall;
      rxd = 1'b0;
      repeat (4) @(negedge clk26m);
      rxd = 1'b1;
      repeat (3 * P) @(negedge clk26m);
      checki("glitch.en_pulses", n_enfall - n0, 1);
      check1("glitch.short", (t_enfall - t_enrise) < P, 1'b1);
      check_all("glitch");
      // overrun, then read, then read coinciding with completion
      frame("ovr1", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame("ovr2", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      read();
      check_all("ovr_read");
      frame("pre44", 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame("pre55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame("rd33", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      // randomized frames against the model
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         pen = 1'($urandom); podd = 1'($urandom); pbit = 1'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         rd = 1'($urandom);
         frame($sformatf("rnd%0d", i), d, pen, podd, pbit, stop, rd);
         if ($urandom_range(0, 1) == 1) read();
      end
      // reset during data bit 4 of a frame, with a byte already held
      read();
      frame("pre_rst", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      d = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rxd = d[4];
      repeat (8) @(negedge clk26m);
      check1("rst.en_before", rx_bps_en, 1'b1);
      rst26m = 1'b1;
      rxd = 1'b1;
      @(negedge clk26m);
      rst26m = 1'b0;
      {m_valid, m_ferr, m_perr, m_ovr} = 4'b0;
      m_data = 8'h00;
      check_all("rst");
      check1("rst.en", rx_bps_en, 1'b0);
      repeat (12 * P) @(negedge clk26m);
      check_all("rst.quiet");
      frame("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
